// File: rtl/wb_arbiter_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_scoreboard
// Brief    : Regfile write-port arbiter (MW priority, multdiv FIFO) with a
//            per-register busy scoreboard driving the decode stall.
//            Optional macro WBQ_BYPASS_EN: zero-latency multdiv write when idle.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int QDEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            dec_rs_addr,
  input  logic [ADDR_W-1:0]            dec_rt_addr,
  input  logic [ADDR_W-1:0]            dec_rd_addr,
  input  logic                         dec_rs_en,
  input  logic                         dec_rt_en,
  input  logic                         dec_rd_en,
  input  logic                         issue_valid,
  input  logic [ADDR_W-1:0]            issue_rd,
  input  logic                         mw_we,
  input  logic [ADDR_W-1:0]            mw_addr,
  input  logic [DATA_W-1:0]            mw_data,
  input  logic                         md_valid,
  input  logic [ADDR_W-1:0]            md_rd,
  input  logic [DATA_W-1:0]            md_data,
  output logic                         md_ready,
  output logic                         rf_we,
  output logic [ADDR_W-1:0]            rf_addr,
  output logic [DATA_W-1:0]            rf_data,
  output logic                         stall,
  output logic [(1<<ADDR_W)-1:0]       busy_vec,
  output logic [$clog2(QDEPTH+1)-1:0]  q_count
);

  localparam int c_nRegs = 1 << ADDR_W;
  localparam int c_cntW  = $clog2(QDEPTH + 1);
  localparam int c_ptrW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  logic [ADDR_W-1:0]  r_qAddr [QDEPTH];
  logic [DATA_W-1:0]  r_qData [QDEPTH];
  logic [c_ptrW-1:0]  r_head;
  logic [c_ptrW-1:0]  r_tail;
  logic [c_cntW-1:0]  r_count;
  logic [c_nRegs-1:0] r_busy;

  logic               w_mwClaim;
  logic               w_pop;
  logic               w_push;
  logic               w_bypass;
  logic               w_mdWrite;
  logic [ADDR_W-1:0]  w_mdAddr;
  logic [c_nRegs-1:0] w_setMask;
  logic [c_nRegs-1:0] w_clrMask;
  logic [c_nRegs-1:0] w_busyNext;

  function automatic logic [c_ptrW-1:0] f_ptrInc(input logic [c_ptrW-1:0] p);
    return (p == c_ptrW'(QDEPTH - 1)) ? '0 : p + c_ptrW'(1);
  endfunction

  assign w_mwClaim = mw_we && (mw_addr != '0);
  assign md_ready  = (r_count < c_cntW'(QDEPTH));
  assign w_pop     = !w_mwClaim && (r_count != '0);

`ifdef WBQ_BYPASS_EN
  assign w_bypass  = md_valid && (md_rd != '0) && !w_mwClaim && (r_count == '0);
`else
  assign w_bypass  = 1'b0;
`endif

  // Results addressed to r0 are accepted (ready) but never stored.
  assign w_push    = md_valid && md_ready && (md_rd != '0) && !w_bypass;

  always_comb begin
    rf_we     = 1'b0;
    rf_addr   = '0;
    rf_data   = '0;
    w_mdWrite = 1'b0;
    w_mdAddr  = '0;
    if (w_mwClaim) begin
      rf_we   = 1'b1;
      rf_addr = mw_addr;
      rf_data = mw_data;
    end else if (w_pop) begin
      rf_we     = 1'b1;
      rf_addr   = r_qAddr[r_head];
      rf_data   = r_qData[r_head];
      w_mdWrite = 1'b1;
      w_mdAddr  = r_qAddr[r_head];
    end else if (w_bypass) begin
      rf_we     = 1'b1;
      rf_addr   = md_rd;
      rf_data   = md_data;
      w_mdWrite = 1'b1;
      w_mdAddr  = md_rd;
    end
  end

  // Set is applied after clear so a same-cycle issue to the register wins.
  assign w_setMask  = (issue_valid && (issue_rd != '0)) ? (c_nRegs'(1) << issue_rd) : '0;
  assign w_clrMask  = w_mdWrite ? (c_nRegs'(1) << w_mdAddr) : '0;
  assign w_busyNext = ((r_busy & ~w_clrMask) | w_setMask) & ~c_nRegs'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_busy  <= '0;
    end else begin
      r_busy <= w_busyNext;
      if (w_push) r_tail <= f_ptrInc(r_tail);
      if (w_pop)  r_head <= f_ptrInc(r_head);
      if (w_push && !w_pop)      r_count <= r_count + c_cntW'(1);
      else if (!w_push && w_pop) r_count <= r_count - c_cntW'(1);
    end
  end

  // Payload storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_qAddr[r_tail] <= md_rd;
      r_qData[r_tail] <= md_data;
    end
  end

  assign stall = (dec_rs_en && (dec_rs_addr != '0) && r_busy[dec_rs_addr]) ||
                 (dec_rt_en && (dec_rt_addr != '0) && r_busy[dec_rt_addr]) ||
                 (dec_rd_en && (dec_rd_addr != '0) && r_busy[dec_rd_addr]);

  assign busy_vec = r_busy;
  assign q_count  = r_count;

endmodule
`default_nettype wire

// File: doc/wb_arbiter_scoreboard.md
Name: wb_arbiter_scoreboard

Overview:
- Successor to the combinational regfile/SX address control.
- Owns the single regfile write port, arbitrating between the in-order MW writeback and out-of-order multdiv results through a pending-write queue.
- Keeps a per-register busy scoreboard for outstanding long-latency ops and raises a decode stall on RAW/WAW hazards.
- Sits between decode, the MW stage, the multdiv unit and the regfile.

Parameters:
- DATA_W, 32, regfile data width
- ADDR_W, 5, register address width; NREGS = 2**ADDR_W
- QDEPTH, 2, pending multdiv write queue depth (>=1)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- dec_rs_addr / dec_rt_addr / dec_rd_addr  in  ADDR_W each  decode source/dest registers
- dec_rs_en / dec_rt_en / dec_rd_en  in  1 each  field is used by the decoding instruction
- issue_valid  in  1  long-latency op leaves DX this cycle
- issue_rd  in  ADDR_W  its destination
- mw_we  in  1  MW stage writeback request
- mw_addr  in  ADDR_W  MW writeback address
- mw_data  in  DATA_W  MW writeback data
- md_valid  in  1  multdiv result offered
- md_rd  in  ADDR_W  multdiv result destination
- md_data  in  DATA_W  multdiv result data
- md_ready  out  1  result accepted when md_valid && md_ready
- rf_we  out  1  regfile write enable
- rf_addr  out  ADDR_W  regfile write address
- rf_data  out  DATA_W  regfile write data
- stall  out  1  hold FD/DX this cycle
- busy_vec  out  NREGS  scoreboard state; bit 0 always 0
- q_count  out  clog2(QDEPTH+1)  queue occupancy

Behaviour:
- Reset (async, any cycle, including mid-drain): queue emptied, q_count=0, busy_vec=0. Combinationally this gives rf_we=0, stall=0, md_ready=1. In-flight queue entries are discarded.
- MW port claim: the MW path claims the write port when mw_we && mw_addr!=0. A claimed port drives rf_we=1, rf_addr=mw_addr, rf_data=mw_data. MW always has priority and is never backpressured.
- md_ready = (q_count < QDEPTH). It is registered-state only and does not depend on mw_we.
- Enqueue: on md_valid && md_ready, push {md_rd, md_data} at the clock edge. Pushes with md_rd==0 are dropped and count is not incremented.
- Drain: when MW does not claim the port and q_count>0, the head drives rf_we/rf_addr/rf_data and is popped at the edge.
- Push and pop may occur in the same cycle; count is unchanged.
- Queue is FIFO. Pointers wrap modulo QDEPTH.
- Scoreboard set: on issue_valid && issue_rd!=0, set busy[issue_rd] at the edge.
- Scoreboard clear: busy[r] is cleared at the edge where a multdiv-sourced write to r appears on the rf port.
- Same register set and cleared in one cycle: set wins.
- MW writes never touch busy.
- Stall (combinational): stall = (rs_en && rs!=0 && busy[rs]) || (rt_en && rt!=0 && busy[rt]) || (rd_en && rd!=0 && busy[rd]).
  - RAW is covered by the rs/rt terms; WAW is covered by the rd term.
  - Stall drops the cycle after the clearing write. The regfile is write-before-read.
- issue_valid while busy[issue_rd]=1 is illegal. The stall rule guarantees it cannot occur.
- Register 0: never marked busy, never written via rf port, never causes a stall.

Optional Feature:
- Macro: WBQ_BYPASS_EN.
- Defined: when q_count==0, MW does not claim the port, and md_valid, the result is written directly that cycle. rf port = md_rd/md_data, no enqueue, busy cleared at that edge. Latency is 0 cycles.
- Undefined: every accepted result goes through the queue. Minimum result-to-write latency is 1 cycle.

Test Plan:
- Reset → busy_vec=0, q_count=0, rf_we=0, md_ready=1, stall=0; assert reset mid-drain → same values immediately.
- Issue rd=5; next cycle decode rs=5 → stall=1. md result r5=0x1234 with MW idle → rf_we, addr 5, data 0x1234 at cycle+1 (cycle+0 with bypass); stall=0 the cycle after.
- MW writes r3=0xAA while md_valid r7=0xBB → rf gets r3/0xAA, q_count=1. Next idle cycle → r7/0xBB, q_count=0, busy[7] cleared.
- MW busy 4 cycles, md offers 3 results, QDEPTH=2 → md_ready=0 after 2 accepted. Third held until a pop; drain order matches push order.
- Issue rd=0 and md result rd=0 → busy_vec unchanged, no rf write, q_count unchanged.
- Issue rd=9; decode with rd_en, rd=9 (WAW) → stall=1 until r9 written by multdiv.
